// File: rtl/mem_access_stage.sv
// ============================================================================
// Module      : mem_access_stage
// Description : Memory-access pipeline stage. Runs loads/stores against a
//               handshaked data-memory port, stalls upstream while an access
//               is outstanding, and loads the MEM/WB register. Misaligned
//               accesses and memory timeouts are squashed and flagged.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        Memory_read_i,
  input  logic        Memory_write_i,
  input  logic [31:0] Data1_i,
  input  logic [31:0] mux7_output_data_i,
  input  logic [4:0]  RDaddr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALUResult_o,
  output logic [4:0]  RDaddr_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Counter value of the last BUSY cycle before the access is aborted.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        regwrite_q, regwrite_d;
  logic        memtoreg_q, memtoreg_d;
  logic [31:0] readdata_q, readdata_d;
  logic [31:0] aluresult_q, aluresult_d;
  logic [4:0]  rdaddr_q, rdaddr_d;
  logic        misalign_q, misalign_d;
  logic        timeout_q, timeout_d;
  logic        stall;

  logic acc;
  logic mis;
  assign acc = Memory_read_i | Memory_write_i;
  assign mis = (Data1_i[1:0] != 2'b00);

  // Next-state, memory-port and MEM/WB load logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    regwrite_d  = RegWrite_i;
    memtoreg_d  = MemtoReg_i;
    readdata_d  = 32'd0;
    aluresult_d = Data1_i;
    rdaddr_d    = RDaddr_i;
    misalign_d  = 1'b0;
    timeout_d   = 1'b0;
    stall       = 1'b0;

    case (state_q)
      IDLE: begin
        if (acc) begin
          if (mis) begin
            // Squash: instruction passes on without writing a register.
            regwrite_d = 1'b0;
            misalign_d = 1'b1;
          end else begin
            stall       = 1'b1;
            state_d     = BUSY;
            req_d       = 1'b1;
            we_d        = Memory_write_i;
            addr_d      = Data1_i;
            wdata_d     = mux7_output_data_i;
            cnt_d       = 8'd0;
            regwrite_d  = 1'b0;
            memtoreg_d  = 1'b0;
            aluresult_d = 32'd0;
            rdaddr_d    = 5'd0;
          end
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          // Ack has priority over a timeout in the same cycle.
          state_d    = IDLE;
          req_d      = 1'b0;
          readdata_d = we_q ? 32'd0 : mem_rdata_i;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          regwrite_d = 1'b0;
          timeout_d  = 1'b1;
        end else begin
          stall       = 1'b1;
          regwrite_d  = 1'b0;
          memtoreg_d  = 1'b0;
          aluresult_d = 32'd0;
          rdaddr_d    = 5'd0;
          if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Stall is masked while reset is held so the stage reports idle at once.
  assign stall_o = stall & rst_i;

  // State, memory-port and MEM/WB registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      readdata_q  <= 32'd0;
      aluresult_q <= 32'd0;
      rdaddr_q    <= 5'd0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      readdata_q  <= readdata_d;
      aluresult_q <= aluresult_d;
      rdaddr_q    <= rdaddr_d;
      misalign_q  <= misalign_d;
      timeout_q   <= timeout_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign RegWrite_o  = regwrite_q;
  assign MemtoReg_o  = memtoreg_q;
  assign ReadData_o  = readdata_q;
  assign ALUResult_o = aluresult_q;
  assign RDaddr_o    = rdaddr_q;
  assign misalign_o  = misalign_q;
  assign timeout_o   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage: directed cases plus
//               randomized instruction stream against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        RegWrite_i, MemtoReg_i, Memory_read_i, Memory_write_i;
  logic [31:0] Data1_i, mux7_output_data_i;
  logic [4:0]  RDaddr_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o, RegWrite_o, MemtoReg_o;
  logic [31:0] ReadData_o, ALUResult_o;
  logic [4:0]  RDaddr_o;
  logic        misalign_o, timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .Memory_read_i(Memory_read_i), .Memory_write_i(Memory_write_i),
    .Data1_i(Data1_i), .mux7_output_data_i(mux7_output_data_i),
    .RDaddr_i(RDaddr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .ReadData_o(ReadData_o), .ALUResult_o(ALUResult_o), .RDaddr_o(RDaddr_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One instruction from EX/MEM until it lands in MEM/WB. ackd is the BUSY
  // cycle (1-based) in which memory acks; 0 means memory never acks.
  // Expected behaviour is computed from the transaction-level rules first.
  task automatic run_instr(input logic rw, input logic mtr, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rdx, input int ackd,
                           input logic [31:0] rdata, input logic late);
    logic        is_acc, is_mis, is_store, acked;
    int          exp_stall;
    logic        exp_rw, exp_mis, exp_to;
    logic [31:0] exp_rd;
    int          n_busy, n_stall;
    logic        done;

    is_acc   = rd | wr;
    is_mis   = is_acc && (addr[1:0] != 2'b00);
    is_store = wr;
    acked    = (ackd >= 1) && (ackd <= TO);
    if (!is_acc || is_mis) begin
      exp_stall = 0;
      exp_rw    = is_mis ? 1'b0 : rw;
      exp_mis   = is_mis;
      exp_to    = 1'b0;
      exp_rd    = 32'd0;
    end else begin
      exp_stall = acked ? ackd : TO;
      exp_rw    = acked ? rw : 1'b0;
      exp_mis   = 1'b0;
      exp_to    = !acked;
      exp_rd    = (acked && !is_store) ? rdata : 32'd0;
    end

    RegWrite_i = rw; MemtoReg_i = mtr; Memory_read_i = rd; Memory_write_i = wr;
    Data1_i = addr; mux7_output_data_i = wdata; RDaddr_i = rdx;
    mem_ack_i = late; mem_rdata_i = rdata;
    n_busy = 0; n_stall = 0; done = 1'b0;

    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk_i);
      if (stall_o) n_stall++;
      done = !stall_o;
      @(posedge clk_i);
      #1;
      if (done) break;
      n_busy++;
      if (n_busy == 1) begin
        check_eq("req_in_busy", {31'd0, mem_req_o}, 32'd1);
        check_eq("we_in_busy", {31'd0, mem_we_o}, {31'd0, is_store});
        check_eq("wdata_in_busy", mem_wdata_o, wdata);
        check_eq("bubble_regwrite", {31'd0, RegWrite_o}, 32'd0);
        check_eq("bubble_memtoreg", {31'd0, MemtoReg_o}, 32'd0);
      end
      mem_ack_i = (n_busy == ackd);
    end
    if (!done) check_eq("instr_completes", 32'd0, 32'd1);
    mem_ack_i = 1'b0;

    check_eq("stall_cycles", n_stall, exp_stall);
    check_eq("req_after", {31'd0, mem_req_o}, 32'd0);
    check_eq("RegWrite_o", {31'd0, RegWrite_o}, {31'd0, exp_rw});
    check_eq("MemtoReg_o", {31'd0, MemtoReg_o}, {31'd0, mtr});
    check_eq("ReadData_o", ReadData_o, exp_rd);
    check_eq("ALUResult_o", ALUResult_o, addr);
    check_eq("RDaddr_o", {27'd0, RDaddr_o}, {27'd0, rdx});
    check_eq("misalign_o", {31'd0, misalign_o}, {31'd0, exp_mis});
    check_eq("timeout_o", {31'd0, timeout_o}, {31'd0, exp_to});
  endtask

  initial begin
    rst_i = 1'b0;
    RegWrite_i = 0; MemtoReg_i = 0; Memory_read_i = 0; Memory_write_i = 0;
    Data1_i = 0; mux7_output_data_i = 0; RDaddr_i = 0;
    mem_ack_i = 0; mem_rdata_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_req", {31'd0, mem_req_o}, 32'd0);
    check_eq("rst_stall", {31'd0, stall_o}, 32'd0);
    check_eq("rst_regwrite", {31'd0, RegWrite_o}, 32'd0);
    check_eq("rst_aluresult", ALUResult_o, 32'd0);
    check_eq("rst_pulses", {30'd0, misalign_o, timeout_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // ALU op passes straight through.
    run_instr(1, 0, 0, 0, 32'h10, 32'h0, 5'd5, 0, 32'h0, 0);
    // Load, ack in third BUSY cycle.
    run_instr(1, 1, 1, 0, 32'h20, 32'h0, 5'd7, 3, 32'hDEADBEEF, 0);
    // Store.
    run_instr(0, 0, 0, 1, 32'h40, 32'h12345678, 5'd0, 2, 32'hFFFF0000, 0);
    // Misaligned load.
    run_instr(1, 1, 1, 0, 32'h22, 32'h0, 5'd3, 1, 32'h0, 0);
    // No ack: timeout, then a late ack in IDLE with an ALU op.
    run_instr(1, 1, 1, 0, 32'h50, 32'h0, 5'd9, 0, 32'hCAFEF00D, 0);
    run_instr(1, 0, 0, 0, 32'h77, 32'h0, 5'd4, 0, 32'h13572468, 1);
    // Ack in the last allowed cycle wins over timeout; minimum stall.
    run_instr(1, 1, 1, 0, 32'h60, 32'h0, 5'd2, TO, 32'hA5A5A5A5, 0);
    run_instr(1, 1, 1, 0, 32'h64, 32'h0, 5'd2, 1, 32'h5A5A5A5A, 0);
    // Read and write together act as a store.
    run_instr(0, 0, 1, 1, 32'h68, 32'h0BADF00D, 5'd1, 2, 32'h11111111, 0);

    // Reset during the second BUSY cycle.
    RegWrite_i = 1; MemtoReg_i = 1; Memory_read_i = 1; Memory_write_i = 0;
    Data1_i = 32'h80; RDaddr_i = 5'd6; mem_ack_i = 0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    check_eq("midrst_req", {31'd0, mem_req_o}, 32'd0);
    check_eq("midrst_stall", {31'd0, stall_o}, 32'd0);
    check_eq("midrst_regwrite", {31'd0, RegWrite_o}, 32'd0);
    check_eq("midrst_memwb", {ReadData_o | ALUResult_o | {27'd0, RDaddr_o} | {31'd0, MemtoReg_o}}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    Memory_read_i = 0;
    @(posedge clk_i); #1;
    run_instr(1, 0, 0, 0, 32'h1234, 32'h0, 5'd11, 0, 32'h0, 0);

    // Randomized instruction stream.
    for (int i = 0; i < 150; i++) begin
      int          kind;
      logic        r, w;
      logic [31:0] a;
      kind = $urandom_range(0, 99);
      a    = $urandom;
      r    = 1'b0;
      w    = 1'b0;
      if (kind >= 40) begin
        case ($urandom_range(0, 2))
          0: r = 1'b1;
          1: w = 1'b1;
          default: begin r = 1'b1; w = 1'b1; end
        endcase
        if (kind >= 55) a[1:0] = 2'b00;
      end
      run_instr($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, r, w, a,
                $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 6),
                $urandom, (kind < 40) && ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the five-stage pipeline, directly downstream of the EX/MEM register. It consumes the registered ALU result, store data, destination register and control bits, and runs loads and stores against a handshaked data-memory port. It stalls the upstream pipeline while an access is outstanding, then loads the MEM/WB register with write-back data and control. Misaligned accesses and memory timeouts are squashed and flagged.

## Interface
- `TIMEOUT`, default 255: maximum number of cycles waited for `mem_ack_i` before the access is aborted. Valid range is 1..255.
- `clk_i` in, 1 bit: clock, rising edge.
- `rst_i` in, 1 bit: reset, asynchronous, active-low.
- `RegWrite_i` in, 1 bit: register-write control from EX/MEM.
- `MemtoReg_i` in, 1 bit: write-back select from EX/MEM.
- `Memory_read_i` in, 1 bit: load request from EX/MEM.
- `Memory_write_i` in, 1 bit: store request from EX/MEM.
- `Data1_i` in, 32 bits: ALU result, used as the memory address.
- `mux7_output_data_i` in, 32 bits: store data.
- `RDaddr_i` in, 5 bits: destination register.
- `mem_req_o` out, 1 bit: memory request. Registered, held until ack or abort.
- `mem_we_o` out, 1 bit: 1 for a store, 0 for a load. Valid while `mem_req_o` is 1.
- `mem_addr_o` out, 32 bits: word address.
- `mem_wdata_o` out, 32 bits: store data.
- `mem_ack_i` in, 1 bit: completion pulse from memory.
- `mem_rdata_i` in, 32 bits: load data, valid in the ack cycle.
- `stall_o` out, 1 bit: combinational. Upstream stages and EX/MEM hold while it is 1.
- `RegWrite_o` out, 1 bit: MEM/WB register-write control.
- `MemtoReg_o` out, 1 bit: MEM/WB write-back select.
- `ReadData_o` out, 32 bits: MEM/WB load data.
- `ALUResult_o` out, 32 bits: MEM/WB ALU result.
- `RDaddr_o` out, 5 bits: MEM/WB destination register.
- `misalign_o` out, 1 bit: one-cycle pulse for a misaligned access.
- `timeout_o` out, 1 bit: one-cycle pulse for an aborted access.

## Operation
- The block has two states, IDLE and BUSY.
- An access is defined as `acc = Memory_read_i | Memory_write_i`.
- The address is misaligned when `mis = Data1_i[1:0] != 0`.
- **IDLE, `acc` = 0:** MEM/WB loads the inputs on each edge. `ReadData_o` loads 0. No stall.
- **IDLE, `acc & mis`:** no memory request is issued. MEM/WB loads with `RegWrite_o` = 0. `misalign_o` pulses for one cycle. No stall.
- **IDLE, `acc & !mis`:** `stall_o` = 1 combinationally.
  - On the edge: go to BUSY, set `mem_req_o` = 1, latch `mem_addr_o`, `mem_wdata_o` and `mem_we_o = Memory_write_i`, clear the timeout counter.
  - MEM/WB loads a bubble (all control 0).
- **BUSY, no ack:** `stall_o` = 1, MEM/WB loads a bubble, the counter increments.
- **BUSY, `mem_ack_i` = 1:**
  - `stall_o` = 0.
  - On the edge: MEM/WB loads the held EX/MEM inputs, with `ReadData_o` = `mem_rdata_i` for a load or 0 for a store. `mem_req_o` drops and the state returns to IDLE.
  - A store commits `RegWrite_i` as presented; normally it is 0.
- **BUSY, counter = `TIMEOUT`-1 and no ack:** abort.
  - `stall_o` = 0.
  - On the edge: `mem_req_o` drops, MEM/WB loads with `RegWrite_o` = 0, `timeout_o` pulses for one cycle, the state returns to IDLE.
  - A late ack arriving in IDLE is ignored.
- `mem_ack_i` is ignored in IDLE.
- EX/MEM inputs are stable while `stall_o` = 1, because EX/MEM is held.
- The timeout counter is 8 bits and saturates; it never wraps.

## Timing
- **Reset values:** every output is 0, the state is IDLE and the counter is 0. Reset in BUSY drops `mem_req_o` at once and the access is lost.
- **Non-memory instruction:** one cycle from EX/MEM to MEM/WB.
- **Load/store with ack after k cycles of `mem_req_o` (k ≥ 1):** `stall_o` is high for k cycles and the result appears in MEM/WB one edge after the ack. The minimum stall is 1 cycle.
- **Back-to-back accesses:** `mem_req_o` is low for at least one cycle between requests, the IDLE cycle.
- **Ack and timeout in the same cycle:** ack wins and the access completes normally.
- **Read and write both asserted:** treated as a store.

## Test plan
- ALU op with `RegWrite_i`=1, `Data1_i`=0x10, `RDaddr_i`=5 → next edge `RegWrite_o`=1, `ALUResult_o`=0x10, `RDaddr_o`=5, `stall_o`=0 throughout.
- Load at address 0x20, memory acks 3 cycles after `mem_req_o` rises with `mem_rdata_i`=0xDEADBEEF → `stall_o` high for 3 cycles, then `ReadData_o`=0xDEADBEEF, `MemtoReg_o`=1, `mem_req_o`=0.
- Store at address 0x40 with data 0x12345678 → `mem_we_o`=1, `mem_wdata_o`=0x12345678 until ack; `RegWrite_o`=0 after completion.
- Load at address 0x22 → no `mem_req_o`, `misalign_o` pulses for 1 cycle, `RegWrite_o`=0, `stall_o`=0.
- `TIMEOUT`=4, no ack → `stall_o` high for 4 cycles, `timeout_o` pulses, `mem_req_o` drops, `RegWrite_o`=0; a late ack is ignored.
- Assert `rst_i`=0 in the second BUSY cycle → `mem_req_o`, `stall_o` and all MEM/WB outputs go to 0 immediately; after release, a fresh ALU op passes through normally.
